// File: rtl/id_hazard_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// id_sched_pkg
// Shared types and constants for the decode-stage hazard scheduler.
//   sched_state_t : scheduler FSM state encoding
//   ALU_LL/ALU_SC : decoder ALU control codes that mark LL/SC instructions
//   STAT_W        : width of the optional hazard statistics counters
// Optional feature macro used by this slice: HAZARD_STATS_EN
// ---------------------------------------------------------------------------
package id_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_LU_STALL    = 3'd1,
        ST_SYS_DRAIN   = 3'd2,
        ST_SYS_NOTIFY  = 3'd3,
        ST_SYS_RELEASE = 3'd4
    } sched_state_t;

    localparam logic [5:0] ALU_LL = 6'b101000;
    localparam logic [5:0] ALU_SC = 6'b110110;
    localparam int         STAT_W = 32;

    // LL/SC go through the drain sequence but must not raise SYS.
    function automatic logic is_llsc(input logic [5:0] alu_control);
        return (alu_control == ALU_LL) || (alu_control == ALU_SC);
    endfunction

endpackage

// File: rtl/id_hazard_scheduler_if.sv
// ---------------------------------------------------------------------------
// id_hazard_scheduler_if
// Bundles the decode-side inputs and the freeze/bubble outputs of the
// hazard scheduler.
//   master : decode/fetch side (drives instruction and EXE info, sees freeze)
//   slave  : scheduler side
// With HAZARD_STATS_EN defined, the three statistics counters are added.
// ---------------------------------------------------------------------------
interface id_hazard_scheduler_if;
    import id_sched_pkg::*;

    logic       Instr_Valid_IN;
    logic       Syscall_IN;
    logic [5:0] ALU_Control_IN;
    logic [4:0] RegA_IN;
    logic [4:0] RegB_IN;
    logic       UsesA_IN;
    logic       UsesB_IN;
    logic       EXE_MemRead_IN;
    logic [4:0] EXE_WriteReg_IN;
    logic       Hit_IN;

    logic       WANT_FREEZE;
    logic       Insert_Bubble;
    logic       Pass_Syscall;
    logic       SYS;
    logic       Busy;

`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] Stat_LoadUse_OUT;
    logic [STAT_W-1:0] Stat_Syscall_OUT;
    logic [STAT_W-1:0] Stat_Miss_OUT;
`endif

    modport master (
        output Instr_Valid_IN, Syscall_IN, ALU_Control_IN, RegA_IN, RegB_IN,
               UsesA_IN, UsesB_IN, EXE_MemRead_IN, EXE_WriteReg_IN, Hit_IN,
        input  WANT_FREEZE, Insert_Bubble, Pass_Syscall, SYS, Busy
`ifdef HAZARD_STATS_EN
        , input Stat_LoadUse_OUT, Stat_Syscall_OUT, Stat_Miss_OUT
`endif
    );

    modport slave (
        input  Instr_Valid_IN, Syscall_IN, ALU_Control_IN, RegA_IN, RegB_IN,
               UsesA_IN, UsesB_IN, EXE_MemRead_IN, EXE_WriteReg_IN, Hit_IN,
        output WANT_FREEZE, Insert_Bubble, Pass_Syscall, SYS, Busy
`ifdef HAZARD_STATS_EN
        , output Stat_LoadUse_OUT, Stat_Syscall_OUT, Stat_Miss_OUT
`endif
    );

endinterface

// File: rtl/id_hazard_scheduler_loaduse.sv
// ---------------------------------------------------------------------------
// id_loaduse_detect
// Pure comparator: flags a load-use hazard when the instruction in EXE is a
// load whose (non-zero) destination is read by the instruction in decode.
//   instr_valid : decode holds a real instruction
//   reg_a/reg_b : rs/rt of decode instruction, uses_a/uses_b qualify them
//   mem_read    : EXE instruction is a load
//   write_reg   : EXE destination register
//   hz          : hazard present
// ---------------------------------------------------------------------------
module id_loaduse_detect (
    input  logic       instr_valid,
    input  logic [4:0] reg_a,
    input  logic [4:0] reg_b,
    input  logic       uses_a,
    input  logic       uses_b,
    input  logic       mem_read,
    input  logic [4:0] write_reg,
    output logic       hz
);

    logic match_a;
    logic match_b;

    assign match_a = uses_a && (reg_a == write_reg);
    assign match_b = uses_b && (reg_b == write_reg);

    // r0 is hardwired zero, so a load targeting it never creates a hazard.
    assign hz = instr_valid && mem_read && (write_reg != 5'd0) && (match_a || match_b);

endmodule

// File: rtl/id_hazard_scheduler.sv
// ---------------------------------------------------------------------------
// id_hazard_scheduler
// Decode-stage stall/bubble scheduler. Arbitrates syscall/LL/SC drain,
// load-use interlock and I-cache miss into fetch freeze, ID->EXE bubble and
// a one-cycle SYS strobe for the simulator.
//
// Parameters:
//   DRAIN_CYCLES         : full-bubble cycles before SYS notify (1..7)
//   LOADUSE_STALL_CYCLES : bubble cycles per load-use hazard (1..3)
// Ports:
//   CLK, RESET (async, active-high)
//   bus (slave modport of id_hazard_scheduler_if): decode inputs in,
//       WANT_FREEZE / Insert_Bubble / Pass_Syscall (combinational),
//       SYS (registered), Busy (state != IDLE)
// Optional: HAZARD_STATS_EN adds saturating per-cause freeze/bubble counters.
//
// state          | meaning
// ---------------+----------------------------------------------------------
// ST_IDLE        | normal decode; syscall > load-use > miss arbitration
// ST_LU_STALL    | extra load-use bubble cycles (only when stall > 1)
// ST_SYS_DRAIN   | full bubbles while older instructions drain
// ST_SYS_NOTIFY  | SYS strobe high; freeze inhibited
// ST_SYS_RELEASE | last bubble, freeze inhibited, back to IDLE next
// ---------------------------------------------------------------------------
module id_hazard_scheduler
    import id_sched_pkg::*;
#(
    parameter int DRAIN_CYCLES         = 3,
    parameter int LOADUSE_STALL_CYCLES = 1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    id_hazard_scheduler_if.slave bus
);

    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);
    localparam logic [2:0] LU_LOAD    = (LOADUSE_STALL_CYCLES > 1) ?
                                        3'(LOADUSE_STALL_CYCLES - 2) : 3'd0;

    sched_state_t state, state_nx;
    logic [2:0]   cnt, cnt_nx;
    logic         llsc, llsc_nx;
    logic         sys_q, sys_nx;
    logic         hz;
    logic         sys_take;
    logic         freeze;
    logic         bubble;
    logic         pass_sys;

    id_loaduse_detect u_loaduse (
        .instr_valid (bus.Instr_Valid_IN),
        .reg_a       (bus.RegA_IN),
        .reg_b       (bus.RegB_IN),
        .uses_a      (bus.UsesA_IN),
        .uses_b      (bus.UsesB_IN),
        .mem_read    (bus.EXE_MemRead_IN),
        .write_reg   (bus.EXE_WriteReg_IN),
        .hz          (hz)
    );

    assign sys_take = bus.Instr_Valid_IN && bus.Syscall_IN;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= ST_IDLE;
            cnt   <= 3'd0;
            llsc  <= 1'b0;
            sys_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            llsc  <= llsc_nx;
            sys_q <= sys_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        llsc_nx  = llsc;
        freeze   = 1'b0;
        bubble   = 1'b0;
        pass_sys = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (sys_take) begin
                    freeze   = 1'b1;
                    bubble   = 1'b1;
                    pass_sys = 1'b1;
                    cnt_nx   = DRAIN_LOAD;
                    llsc_nx  = is_llsc(bus.ALU_Control_IN);
                    state_nx = ST_SYS_DRAIN;
                end else if (hz) begin
                    freeze = 1'b1;
                    bubble = 1'b1;
                    if (LOADUSE_STALL_CYCLES > 1) begin
                        cnt_nx   = LU_LOAD;
                        state_nx = ST_LU_STALL;
                    end
                end else begin
                    freeze = !bus.Hit_IN;
                end
            end
            ST_LU_STALL: begin
                freeze = 1'b1;
                bubble = 1'b1;
                if (cnt == 3'd0) state_nx = ST_IDLE;
                else             cnt_nx   = cnt - 3'd1;
            end
            ST_SYS_DRAIN: begin
                freeze = 1'b1;
                bubble = 1'b1;
                if (cnt == 3'd0) state_nx = ST_SYS_NOTIFY;
                else             cnt_nx   = cnt - 3'd1;
            end
            ST_SYS_NOTIFY: begin
                // Freeze is inhibited here even on a miss so fetch can
                // observe the post-syscall PC redirect.
                bubble   = 1'b1;
                state_nx = ST_SYS_RELEASE;
            end
            ST_SYS_RELEASE: begin
                bubble   = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // SYS rises on the edge that enters SYS_NOTIFY and falls on the next one.
    assign sys_nx = (state == ST_SYS_DRAIN) && (cnt == 3'd0) && !llsc;

    assign bus.WANT_FREEZE   = freeze;
    assign bus.Insert_Bubble = bubble;
    assign bus.Pass_Syscall  = pass_sys;
    assign bus.SYS           = sys_q;
    assign bus.Busy          = (state != ST_IDLE);

`ifdef HAZARD_STATS_EN
    logic              lu_cyc;
    logic              sc_cyc;
    logic              miss_cyc;
    logic [STAT_W-1:0] stat_lu;
    logic [STAT_W-1:0] stat_sc;
    logic [STAT_W-1:0] stat_miss;

    assign lu_cyc   = ((state == ST_IDLE) && !sys_take && hz) || (state == ST_LU_STALL);
    assign sc_cyc   = ((state == ST_IDLE) && sys_take) || (state == ST_SYS_DRAIN) ||
                      (state == ST_SYS_NOTIFY) || (state == ST_SYS_RELEASE);
    assign miss_cyc = (state == ST_IDLE) && !sys_take && !hz && !bus.Hit_IN;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stat_lu   <= '0;
            stat_sc   <= '0;
            stat_miss <= '0;
        end else begin
            if (lu_cyc   && (stat_lu   != '1)) stat_lu   <= stat_lu   + 1'b1;
            if (sc_cyc   && (stat_sc   != '1)) stat_sc   <= stat_sc   + 1'b1;
            if (miss_cyc && (stat_miss != '1)) stat_miss <= stat_miss + 1'b1;
        end
    end

    assign bus.Stat_LoadUse_OUT = stat_lu;
    assign bus.Stat_Syscall_OUT = stat_sc;
    assign bus.Stat_Miss_OUT    = stat_miss;
`endif

endmodule

// File: tb/tb_id_hazard_scheduler.sv
// ---------------------------------------------------------------------------
// tb_id_hazard_scheduler
// Scoreboard bench for id_hazard_scheduler. The reference model keeps a
// queue of pre-scheduled per-cycle outputs: a syscall or load-use event
// enqueues its whole bubble train at once; with nothing scheduled, outputs
// follow the idle arbitration rules directly.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_id_hazard_scheduler;
    import id_sched_pkg::*;

    localparam int DC = 3;
    localparam int LU = 1;

    localparam int C_NONE = 0;
    localparam int C_LU   = 1;
    localparam int C_SC   = 2;
    localparam int C_MISS = 3;

    typedef struct {
        logic freeze;
        logic bubble;
        logic pass;
        logic sys;
        logic busy;
        int   cause;
        int   st_lu;
        int   st_sc;
        int   st_miss;
    } exp_t;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    id_hazard_scheduler_if bus ();

    id_hazard_scheduler #(
        .DRAIN_CYCLES         (DC),
        .LOADUSE_STALL_CYCLES (LU)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    exp_t sched[$];
    exp_t expq[$];
    int   m_lu, m_sc, m_miss;
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t mk(logic f, logic b, logic p, logic s, logic y, int c);
        exp_t e;
        e.freeze = f; e.bubble = b; e.pass = p; e.sys = s; e.busy = y; e.cause = c;
        e.st_lu = 0; e.st_sc = 0; e.st_miss = 0;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    // Reference: evaluated once per cycle with the inputs just driven.
    task automatic model_step(input logic v, input logic sc, input logic [5:0] alu,
                              input logic [4:0] ra, input logic [4:0] rb,
                              input logic ua, input logic ub, input logic mr,
                              input logic [4:0] wr, input logic hit, output exp_t e);
        logic hzm;
        logic ll;
        hzm = v && mr && (wr != 0) && ((ua && ra == wr) || (ub && rb == wr));
        if (sched.size() > 0) begin
            e = sched.pop_front();
        end else if (v && sc) begin
            ll = (alu == ALU_LL) || (alu == ALU_SC);
            e = mk(1, 1, 1, 0, 0, C_SC);
            for (int i = 0; i < DC; i++) sched.push_back(mk(1, 1, 0, 0, 1, C_SC));
            sched.push_back(mk(0, 1, 0, !ll, 1, C_SC));
            sched.push_back(mk(0, 1, 0, 0, 1, C_SC));
        end else if (hzm) begin
            e = mk(1, 1, 0, 0, 0, C_LU);
            for (int i = 1; i < LU; i++) sched.push_back(mk(1, 1, 0, 0, 1, C_LU));
        end else begin
            e = mk(!hit, 0, 0, 0, 0, hit ? C_NONE : C_MISS);
        end
        e.st_lu = m_lu; e.st_sc = m_sc; e.st_miss = m_miss;
        if (e.cause == C_LU)   m_lu++;
        if (e.cause == C_SC)   m_sc++;
        if (e.cause == C_MISS) m_miss++;
    endtask

    // Drive one cycle of inputs shortly after the rising edge.
    task automatic cyc(input logic v, input logic sc, input logic [5:0] alu,
                       input logic [4:0] ra, input logic [4:0] rb,
                       input logic ua, input logic ub, input logic mr,
                       input logic [4:0] wr, input logic hit);
        exp_t e;
        @(posedge CLK); #1;
        RESET = 1'b0;
        bus.Instr_Valid_IN = v;  bus.Syscall_IN = sc;  bus.ALU_Control_IN = alu;
        bus.RegA_IN = ra;        bus.RegB_IN = rb;     bus.UsesA_IN = ua;
        bus.UsesB_IN = ub;       bus.EXE_MemRead_IN = mr;
        bus.EXE_WriteReg_IN = wr; bus.Hit_IN = hit;
        model_step(v, sc, alu, ra, rb, ua, ub, mr, wr, hit, e);
        expq.push_back(e);
    endtask

    task automatic idle(input int n, input logic hit);
        for (int i = 0; i < n; i++) cyc(0, 0, 6'd0, 5'd0, 5'd0, 0, 0, 0, 5'd0, hit);
    endtask

    // One cycle held in reset; the model forgets everything it scheduled.
    task automatic rst_cyc();
        exp_t e;
        @(posedge CLK); #1;
        RESET = 1'b1;
        bus.Instr_Valid_IN = 0; bus.Syscall_IN = 0; bus.ALU_Control_IN = 0;
        bus.RegA_IN = 0; bus.RegB_IN = 0; bus.UsesA_IN = 0; bus.UsesB_IN = 0;
        bus.EXE_MemRead_IN = 0; bus.EXE_WriteReg_IN = 0; bus.Hit_IN = 1;
        sched.delete();
        m_lu = 0; m_sc = 0; m_miss = 0;
        e = mk(0, 0, 0, 0, 0, C_NONE);
        expq.push_back(e);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("freeze", int'(bus.WANT_FREEZE),   int'(e.freeze));
            chk("bubble", int'(bus.Insert_Bubble), int'(e.bubble));
            chk("pass",   int'(bus.Pass_Syscall),  int'(e.pass));
            chk("sys",    int'(bus.SYS),           int'(e.sys));
            chk("busy",   int'(bus.Busy),          int'(e.busy));
`ifdef HAZARD_STATS_EN
            chk("stat_lu",   int'(bus.Stat_LoadUse_OUT), e.st_lu);
            chk("stat_sc",   int'(bus.Stat_Syscall_OUT), e.st_sc);
            chk("stat_miss", int'(bus.Stat_Miss_OUT),    e.st_miss);
`endif
        end
    end

    initial begin
        logic [5:0] alu;
        int         pick;
        RESET = 1'b1;
        m_lu = 0; m_sc = 0; m_miss = 0;
        rst_cyc();
        rst_cyc();
        idle(2, 1);

        // load-use on rs, one bubble, then released
        cyc(1, 0, 6'd0, 5'd5, 5'd0, 1, 0, 1, 5'd5, 1);
        idle(2, 1);
        // same with r0 destination: no stall
        cyc(1, 0, 6'd0, 5'd0, 5'd0, 1, 0, 1, 5'd0, 1);
        // load-use through rt only
        cyc(1, 0, 6'd0, 5'd1, 5'd9, 0, 1, 1, 5'd9, 1);
        idle(1, 1);

        // plain syscall
        cyc(1, 1, 6'd0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1);
        idle(7, 1);
        // LL and SC: same timing, no SYS
        cyc(1, 1, ALU_LL, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1);
        idle(7, 1);
        cyc(1, 1, ALU_SC, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1);
        idle(7, 1);

        // miss held through a syscall sequence
        cyc(1, 1, 6'd0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0);
        idle(7, 0);
        idle(1, 1);

        // syscall together with a load-use hazard
        cyc(1, 1, 6'd0, 5'd7, 5'd0, 1, 0, 1, 5'd7, 1);
        idle(7, 1);

        // back-to-back syscalls held on the input
        for (int i = 0; i < 13; i++) cyc(1, 1, 6'd0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1);
        idle(6, 1);

        // reset in the middle of the drain
        cyc(1, 1, 6'd0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1);
        idle(2, 1);
        rst_cyc();
        idle(6, 1);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            pick = $urandom_range(0, 3);
            alu  = (pick == 0) ? ALU_LL : (pick == 1) ? ALU_SC : 6'($urandom);
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 11) == 0, alu,
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), 1'($urandom),
                5'($urandom_range(0, 3)), $urandom_range(0, 4) != 0);
            if ($urandom_range(0, 299) == 0) rst_cyc();
        end
        idle(8, 1);

        for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge CLK);
        if (expq.size() > 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_hazard_scheduler.md
Name: id_hazard_scheduler

Overview:
Stall/bubble scheduler for the decode stage. It arbitrates the three freeze sources: the syscall/LL/SC drain sequence, the load-use interlock and the instruction-cache miss. From them it generates the fetch freeze, the ID-to-EXE bubble-insert and the one-cycle SYS notification. It sits beside the decode stage, replacing the ad-hoc bubble counter, and feeds fetch, decode and the simulator.

Parameters:
DRAIN_CYCLES, 3, full-bubble cycles between syscall detection and SYS notify (legal 1..7)
LOADUSE_STALL_CYCLES, 1, bubble cycles per load-use hazard (legal 1..3)

Ports:
CLK  in  1  clock
RESET  in  1  asynchronous reset, active-high
Instr_Valid_IN  in  1  decode holds a real instruction
Syscall_IN  in  1  decoder flags syscall/LL/SC (flush class)
ALU_Control_IN  in  6  decoder ALU control of current instruction
RegA_IN  in  5  rs of current instruction
RegB_IN  in  5  rt of current instruction
UsesA_IN  in  1  rs is read
UsesB_IN  in  1  rt is read
EXE_MemRead_IN  in  1  instruction now in EXE is a load
EXE_WriteReg_IN  in  5  destination of instruction in EXE
Hit_IN  in  1  instruction cache hit
WANT_FREEZE  out  1  fetch holds PC and instruction (combinational)
Insert_Bubble  out  1  decode sends all-zero control to EXE this cycle (combinational)
Pass_Syscall  out  1  bubble carries the syscall word for MEM flush (combinational)
SYS  out  1  simulator system-call strobe (registered)
Busy  out  1  state != IDLE

Behaviour:
- States: IDLE, LU_STALL, SYS_DRAIN, SYS_NOTIFY, SYS_RELEASE. 3-bit counter cnt. Latched flag llsc.
- Reset (async, RESET=1): state=IDLE, cnt=0, llsc=0, SYS=0. All combinational outputs then evaluate from the IDLE rules. Reset mid-sequence abandons the sequence and produces no SYS pulse.
- Hazard term hz = Instr_Valid_IN & EXE_MemRead_IN & (EXE_WriteReg_IN!=0) & ((UsesA_IN & RegA_IN==EXE_WriteReg_IN) | (UsesB_IN & RegB_IN==EXE_WriteReg_IN)).
- IDLE priority: syscall > hz > miss.
  - Instr_Valid_IN & Syscall_IN: freeze=1, bubble=1, Pass_Syscall=1; cnt<=DRAIN_CYCLES-1; llsc<=(ALU_Control_IN==ALU_LL | ALU_Control_IN==ALU_SC); next state SYS_DRAIN.
  - Else hz: freeze=1, bubble=1. If LOADUSE_STALL_CYCLES>1, go to LU_STALL with cnt<=LOADUSE_STALL_CYCLES-2; otherwise stay in IDLE.
  - Else: freeze=!Hit_IN, bubble=0.
- LU_STALL: freeze=1, bubble=1. Go to IDLE when cnt==0, else cnt--. A syscall is not accepted until IDLE is reached.
- SYS_DRAIN: freeze=1, bubble=1, Pass_Syscall=0. Go to SYS_NOTIFY when cnt==0, else cnt--. Hit_IN is ignored.
- SYS_NOTIFY: freeze=0 (inhibit overrides a miss), bubble=1. Next state SYS_RELEASE.
- SYS_RELEASE: freeze=0, bubble=1. Next state IDLE.
- SYS is a register: set to !llsc on entry to SYS_NOTIFY, cleared on the next edge. It is high exactly during the SYS_NOTIFY cycle and never high for LL/SC.
- Back-to-back syscalls: a syscall present in the first IDLE cycle after SYS_RELEASE starts a new full sequence. There is no merging.
- Syscall sequence length = 1 (detect) + DRAIN_CYCLES + 2 cycles. Default: 6 cycles, with SYS in the 5th cycle.

Optional Feature:
HAZARD_STATS_EN
- Defined: adds outputs Stat_LoadUse_OUT[31:0], Stat_Syscall_OUT[31:0] and Stat_Miss_OUT[31:0].
  - Each is a saturating counter of cycles with WANT_FREEZE|Insert_Bubble attributed to that cause; miss counts only in IDLE with no hz.
  - Counters clear on RESET.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package id_sched_pkg: state enum, ALU_LL=6'b101000, ALU_SC=6'b110110, STAT_W=32.
- Sub-module id_loaduse_detect: computes hz only (pure comparator). The FSM stays in the top.

Test Plan:
- Load-use: EXE_MemRead_IN=1, EXE_WriteReg_IN=5, RegA_IN=5, UsesA_IN=1 → Insert_Bubble=WANT_FREEZE=1 for exactly 1 cycle; same case with EXE_WriteReg_IN=0 → no stall.
- Syscall: Syscall_IN=1, ALU_Control_IN=0 in IDLE → freeze for cycles 1–4, SYS=1 only in cycle 5, Busy low from cycle 7.
- LL: Syscall_IN=1, ALU_Control_IN=6'b101000 → same 6-cycle timing, SYS stays 0.
- Miss vs inhibit: Hit_IN=0 held through a syscall sequence → WANT_FREEZE=0 in SYS_NOTIFY and SYS_RELEASE, 1 elsewhere.
- Priority: Syscall_IN=1 together with hz=1 → syscall path taken, Pass_Syscall=1 in cycle 1.
- Reset: RESET pulsed during SYS_DRAIN → state IDLE immediately, no SYS pulse; with HAZARD_STATS_EN defined, counters read 0.
